// File: rtl/sr_round_pkg.sv
// Shared FPU definitions: class-flag struct, LFSR constants and LFSR helpers
// used by the multiplier stages.
package sr_round_pkg;

  typedef struct packed {
    logic zero;
    logic inf;
    logic subN;
    logic Norm;
    logic QNan;
    logic SNan;
  } fp_class_t;

  localparam fp_class_t CLASS_NONE = 6'b000000;
  localparam logic [15:0] LFSR_MASK  = 16'hB400;
  localparam logic [15:0] LFSR_RESET = 16'hACE1;

  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    return (s >> 1) ^ (s[0] ? LFSR_MASK : 16'h0000);
  endfunction

  // An all-zero state would lock the LFSR, so it is never loaded.
  function automatic logic [15:0] seed_fix(input logic [15:0] s);
    return (s == 16'h0000) ? LFSR_RESET : s;
  endfunction

endpackage

// File: rtl/sr_round_if.sv
// Beat, seed and test signals between the multiplier, the stochastic-rounding
// stage and its consumer.
interface sr_round_if #(
  parameter int num_bits       = 16,
  parameter int mant_width     = 10,
  parameter int num_round_bits = 8
);
  logic                               in_valid;
  logic                               in_ready;
  logic [num_bits-1:0]                in_result;
  logic [mant_width+num_round_bits-1:0] in_round_mant;
  logic                               in_zero, in_inf, in_subN, in_Norm, in_QNan, in_SNan;
  logic                               seed_load;
  logic [15:0]                        seed;
  logic                               out_valid;
  logic                               out_ready;
  logic [num_bits-1:0]                out_result;
  logic                               out_zero, out_inf, out_subN, out_Norm, out_QNan, out_SNan;
  logic [15:0]                        lfsr_t;

  modport master (
    output in_valid, in_result, in_round_mant,
           in_zero, in_inf, in_subN, in_Norm, in_QNan, in_SNan,
           seed_load, seed, out_ready,
    input  in_ready, out_valid, out_result,
           out_zero, out_inf, out_subN, out_Norm, out_QNan, out_SNan, lfsr_t
  );

  modport slave (
    input  in_valid, in_result, in_round_mant,
           in_zero, in_inf, in_subN, in_Norm, in_QNan, in_SNan,
           seed_load, seed, out_ready,
    output in_ready, out_valid, out_result,
           out_zero, out_inf, out_subN, out_Norm, out_QNan, out_SNan, lfsr_t
  );
endinterface

// File: rtl/sr_lfsr.sv
// 16-bit right-shifting Galois LFSR with seed load (priority) and advance enable.
module sr_lfsr
  import sr_round_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic [15:0] seed,
  input  logic        adv,
  output logic [15:0] state
);

  logic [15:0] state_r;
  logic [15:0] next_s;

  // Next state: a seed load overrides the advance.
  always_comb begin
    next_s = state_r;
    if (load) begin
      next_s = seed_fix(seed);
    end else if (adv) begin
      next_s = lfsr_next(state_r);
    end else begin
      next_s = state_r;
    end
  end

  // State register; reset also masks any seed load.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= LFSR_RESET;
    end else begin
      state_r <= next_s;
    end
  end

  assign state = state_r;

endmodule

// File: rtl/sr_round.sv
// Stochastic-rounding stage: 2-deep valid/ready pipeline that rounds the
// magnitude up with probability frac / 2^num_round_bits.
module sr_round
  import sr_round_pkg::*;
#(
  parameter int num_round_bits = 8,
  parameter int num_bits       = 16,
  parameter int exp_width      = 5,
  parameter int mant_width     = 10
) (
  input  logic    clk,
  input  logic    rst,
  sr_round_if.slave bus
);

  localparam int MAG_W = num_bits - 1;

  logic                      s1_valid_r;
  logic [num_bits-1:0]       s1_result_r;
  logic [num_round_bits-1:0] s1_frac_r;
  logic [num_round_bits-1:0] s1_rnd_r;
  fp_class_t                 s1_cls_r;

  logic                      out_valid_r;
  logic [num_bits-1:0]       out_result_r;
  fp_class_t                 out_cls_r;

  logic                      s1_en_s, s2_en_s, in_hs_s;
  logic [15:0]               lfsr_state_s;
  fp_class_t                 in_cls_s;
  logic                      carry_s, inc_s;
  logic [MAG_W-1:0]          mag_s;
  logic [exp_width-1:0]      exp_s;
  logic [num_bits-1:0]       res_s;
  fp_class_t                 cls_s;
  logic                      unused_mant_s;

  assign s2_en_s      = bus.out_ready | ~out_valid_r;
  assign s1_en_s      = s2_en_s | ~s1_valid_r;
  assign bus.in_ready = s1_en_s & ~rst;
  assign in_hs_s      = bus.in_valid & bus.in_ready;

  assign in_cls_s = '{zero: bus.in_zero, inf: bus.in_inf, subN: bus.in_subN,
                      Norm: bus.in_Norm, QNan: bus.in_QNan, SNan: bus.in_SNan};

  assign unused_mant_s = ^bus.in_round_mant[mant_width+num_round_bits-1:num_round_bits];

  sr_lfsr u_lfsr (
    .clk   (clk),
    .rst   (rst),
    .load  (bus.seed_load),
    .seed  (bus.seed),
    .adv   (in_hs_s),
    .state (lfsr_state_s)
  );

  // Rounding adder and class recompute on the stage-1 contents.
  always_comb begin
    carry_s = ({1'b0, s1_frac_r} + {1'b0, s1_rnd_r}) > {1'b0, {num_round_bits{1'b1}}};
    inc_s   = carry_s & (s1_cls_r.Norm | s1_cls_r.subN);
    mag_s   = s1_result_r[MAG_W-1:0] + {{(MAG_W-1){1'b0}}, inc_s};
    exp_s   = mag_s[mant_width +: exp_width];
    res_s   = {s1_result_r[num_bits-1], mag_s};
    cls_s   = s1_cls_r;
    if (inc_s && (exp_s == {exp_width{1'b1}})) begin
      cls_s     = CLASS_NONE;
      cls_s.inf = 1'b1;
    end else if (inc_s && s1_cls_r.subN && (exp_s == {{(exp_width-1){1'b0}}, 1'b1})) begin
      cls_s      = CLASS_NONE;
      cls_s.Norm = 1'b1;
    end else begin
      cls_s = s1_cls_r;
    end
  end

  // Stage 1: capture the beat together with the pre-advance random sample.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_r  <= 1'b0;
      s1_result_r <= {num_bits{1'b0}};
      s1_frac_r   <= {num_round_bits{1'b0}};
      s1_rnd_r    <= {num_round_bits{1'b0}};
      s1_cls_r    <= CLASS_NONE;
    end else if (s1_en_s) begin
      s1_valid_r <= in_hs_s;
      if (in_hs_s) begin
        s1_result_r <= bus.in_result;
        s1_frac_r   <= bus.in_round_mant[num_round_bits-1:0];
        s1_rnd_r    <= lfsr_state_s[num_round_bits-1:0];
        s1_cls_r    <= in_cls_s;
      end
    end
  end

  // Stage 2: registered output, held while the consumer stalls.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_r  <= 1'b0;
      out_result_r <= {num_bits{1'b0}};
      out_cls_r    <= CLASS_NONE;
    end else if (s2_en_s) begin
      out_valid_r <= s1_valid_r;
      if (s1_valid_r) begin
        out_result_r <= res_s;
        out_cls_r    <= cls_s;
      end
    end
  end

  assign bus.out_valid  = out_valid_r;
  assign bus.out_result = out_result_r;
  assign bus.out_zero   = out_cls_r.zero;
  assign bus.out_inf    = out_cls_r.inf;
  assign bus.out_subN   = out_cls_r.subN;
  assign bus.out_Norm   = out_cls_r.Norm;
  assign bus.out_QNan   = out_cls_r.QNan;
  assign bus.out_SNan   = out_cls_r.SNan;
  assign bus.lfsr_t     = lfsr_state_s;

endmodule

// File: doc/sr_round.md
# sr_round

Stochastic-rounding stage placed directly after the half/single-precision multiplier. It accepts the multiplier's truncated result, its extended mantissa (`round_mant`, carrying `num_round_bits` guard bits below the LSB) and its class flags. It rounds the magnitude up with probability `frac / 2^num_round_bits`, using an internal 16-bit LFSR. The stage is a 2-deep valid/ready pipeline with full throughput and back-pressure.

## Interface
Parameters:
- `num_round_bits`, 8: width of the discarded fraction. Legal range is 1..16.
- `num_bits`, 16: format width (16 or 32).
- `exp_width`, 5: exponent field width.
- `mant_width`, 10: stored mantissa width.

Ports (one clock; reset is synchronous and active-high):
- `clk`  in  1: clock. All state updates on the rising edge.
- `rst`  in  1: synchronous, active-high reset.
- `in_valid`  in  1: input beat valid.
- `in_ready`  out  1: stage can accept a beat this cycle.
- `in_result`  in  `num_bits`: truncated result from the multiplier.
- `in_round_mant`  in  `mant_width+num_round_bits`: the low `num_round_bits` bits are the discarded fraction `frac`.
- `in_zero, in_inf, in_subN, in_Norm, in_QNan, in_SNan`  in  1 each: one-hot class of `in_result`.
- `seed_load`  in  1: load `seed` into the LFSR.
- `seed`  in  16: LFSR seed.
- `out_valid`  out  1: output beat valid.
- `out_ready`  in  1: consumer accepts the output beat.
- `out_result`  out  `num_bits`: rounded result.
- `out_zero, out_inf, out_subN, out_Norm, out_QNan, out_SNan`  out  1 each: class of `out_result`.
- `lfsr_t`  out  16: current LFSR state (test output).

## Operation
- **LFSR:** Galois, right-shifting, mask 16'hB400: `next = (s>>1) ^ (s[0] ? 16'hB400 : 0)`.
  - The random sample is `rnd = s[num_round_bits-1:0]`, taken from the state before advancing.
  - The LFSR advances only on an input handshake (`in_valid & in_ready`).
- **Seed load:** `seed_load` writes `seed`; a seed of 0 is replaced by 16'hACE1.
  - `seed_load` has priority over advancing in the same cycle.
  - A beat accepted in that cycle samples the pre-load state.
- **Stage 1:** registers `in_result`, `frac`, `rnd` and the flags on handshake.
- **Stage 2:** computes the carry `c = ({1'b0,frac} + {1'b0,rnd})[num_round_bits]`.
  - The increment is applied only if `in_Norm | in_subN`.
  - Increment rule: magnitude `M = result[num_bits-2:0]`, `M' = M + c`; the sign is unchanged.
  - Width: `M'` is computed `num_bits-1` bits wide. Carries propagate mantissa → exponent naturally.
- **Class recompute after increment:**
  - `exp' == all-ones` → `out_inf=1`, mantissa is 0 by construction (overflow from max Norm).
  - subN whose `exp'` became 1 → `out_Norm=1` (promotion).
  - Otherwise the input class is kept.
- **Pass-through:** zero, inf, QNan and SNan beats pass unmodified. They still consume one LFSR step, so the random stream is independent of data class.

## Timing
- Latency: 2 cycles from input handshake to `out_valid` when not stalled. Throughput is 1 beat/cycle.
- **Stage enables:**
  - `s2_en = out_ready | ~out_valid`.
  - `s1_en = s2_en | ~s1_valid`.
  - `in_ready = s1_en`, a combinational function of `out_ready` and internal valids.
- **Hold rule:** `out_valid` and the output data hold stable while `out_valid & ~out_ready`. At most 2 beats are in flight; no beat is dropped or duplicated.
- **Simultaneous events:** an output handshake and an input handshake in the same cycle keep the pipe full with no bubble.
- **Reset values:**
  - `out_valid=0`, `s1_valid=0`, `out_result=0`, all out flags 0, LFSR=16'hACE1.
  - `in_ready=1` in the cycle after reset releases; `in_ready=0` while `rst` is high.
- **Reset mid-operation:** in-flight beats are discarded and the LFSR reloads 16'hACE1; `seed_load` during `rst` is ignored.

## Structure
- Shared FPU package (used by all stages) holds:
  - the class-flag struct `{zero,inf,subN,Norm,QNan,SNan}`,
  - `LFSR_MASK` (16'hB400),
  - `LFSR_RESET` (16'hACE1).
- One sub-module, `sr_lfsr`: the 16-bit LFSR with seed load, advance enable and state output.
- The rounding adder and class recompute stay inline in `sr_round`.

## Test plan
All scenarios use FP16, `num_round_bits=8`.
- **Carry into exponent:** `seed_load`, `seed=16'h0001`; then beat `in_result=16'h3BFF`, `frac=8'hFF`, Norm (rnd=01, carry) → `out_result=16'h3C00`, Norm, 2 cycles later. The following beat samples rnd=8'h00 (state 16'hB400).
- **Overflow to inf:** seed 16'h0001; beat `16'h7BFF`, `frac=8'hFF`, Norm → `16'h7C00`, `out_inf=1`. Also beat `frac=8'h00` with any seed → `out_result` equals input for 1000 random Norm inputs.
- **SubN promotion:** seed 16'h0001; beat `16'h83FF`, `frac=8'hFF`, subN → `16'h8400`, `out_Norm=1`, sign kept.
- **NaN / zero pass-through:**
  - `16'h7E00` QNan with `frac=8'hFF` → `16'h7E00`, QNan, unchanged.
  - Zero `16'h8000` → unchanged.
  - `lfsr_t` advances once per beat.
- **Back-pressure:** hold `out_ready=0` for 5 cycles while offering 4 beats → exactly 2 accepted, `in_ready=0` afterwards, output stable. Release → the beats emerge in order, the rest are accepted with no loss, and the LFSR advanced exactly once per accepted beat.
- **Reset mid-flight:** assert `rst` with 2 beats in flight → next cycle `out_valid=0` and `lfsr_t=16'hACE1`. Statistical check: 10000 beats with `frac=8'h40` increment 25% ±1.5%.
